// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I width codes,
// FSM states and the lane mask used by the sub-word store merge.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_e;

  // Bits of the word covered by an access of the given width at byte offset off.
  function automatic logic [31:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [31:0] mask;
    case (funct3[1:0])
      2'b00:   mask = 32'h0000_00FF << {off, 3'b000};
      2'b01:   mask = 32'h0000_FFFF << {off[1], 4'b0000};
      default: mask = '1;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the addressed byte/halfword out of a memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'(rdata >> {addr, 3'b000});
    lane_h = 16'(rdata >> {addr[1], 4'b0000});
    case (funct3)
      F3_B:    value = {{24{lane_b[7]}}, lane_b};
      F3_BU:   value = {24'h0, lane_b};
      F3_H:    value = {{16{lane_h[15]}}, lane_h};
      F3_HU:   value = {16'h0, lane_h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Sub-word stores are a read-modify-write spread over the accept and MERGE cycles.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state;
  logic [31:0] merge_addr;
  logic [31:0] merge_data;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal;
  logic        err;
  logic        word_store;
  logic        sub_store;
  logic [31:0] mask;
  logic [31:0] merged;
  logic [31:0] load_value;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = |req_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (req_addr >= 32'(MEM_BYTES));
  assign illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                        (req_we && req_funct3[2]);
  assign err          = misaligned || out_of_range || illegal;

  // Legal store codes are only B/H/W, so anything that is not W is a sub-word store.
  assign word_store = accept && !err && req_we && (req_funct3 == F3_W);
  assign sub_store  = accept && !err && req_we && (req_funct3 != F3_W);

  assign mask   = lane_mask(req_funct3, req_addr[1:0]);
  assign merged = (mem_rdata & ~mask) | ((req_wdata << {req_addr[1:0], 3'b000}) & mask);

  lsu_load_align u_align (
    .rdata  (mem_rdata),
    .addr   (req_addr[1:0]),
    .funct3 (req_funct3),
    .value  (load_value)
  );

  // rst_n gates the write strobe directly so a reset during MERGE drops it at once.
  always_comb begin
    if (state == MERGE) begin
      mem_addr  = merge_addr;
      mem_wdata = merge_data;
      mem_we    = rst_n;
    end else begin
      mem_addr  = {req_addr[31:2], 2'b00};
      mem_wdata = req_wdata;
      mem_we    = rst_n && word_store;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      merge_addr <= '0;
      merge_data <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (sub_store) begin
              state      <= MERGE;
              merge_addr <= {req_addr[31:2], 2'b00};
              merge_data <= merged;
            end else begin
              resp_valid <= 1'b1;
              if (!req_we) resp_rdata <= load_value;
            end
          end
        end
        MERGE: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios followed by random traffic,
// checked each cycle against a byte-level memory model and a response-timing queue.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_lsu #(.MEM_BYTES(4096)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory that the DUT drives.
  logic [31:0] dmem [0:1023];
  assign mem_rdata = dmem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[11:2]] <= mem_wdata;

  // Reference state.
  logic [31:0] ref_mem [0:1023];
  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t        rsp_q [$];
  int unsigned cyc;
  logic        merge_pending;
  int unsigned merge_due;
  logic [31:0] merge_a;
  logic [31:0] merge_d;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad_f3, mis;
    bad_f3 = (f3 == 3 || f3 == 6 || f3 == 7) || (we && f3 >= 4);
    mis    = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
    return bad_f3 || mis || (a >= 4096);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, v;
    w = ref_mem[a[11:2]];
    v = w >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v | 32'hFFFF_FF00; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v | 32'hFFFF_0000; end
      3'd5: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
    logic [31:0] w;
    int unsigned off, n;
    if (ref_err(we, f3, a)) begin
      rsp_q.push_back('{due: cyc + 1, err: 1'b1, rdata: 32'h0});
    end else if (!we) begin
      rsp_q.push_back('{due: cyc + 1, err: 1'b0, rdata: ref_load(f3, a)});
    end else if (f3 == 3'd2) begin
      ref_mem[a[11:2]] = wd;
      rsp_q.push_back('{due: cyc + 1, err: 1'b0, rdata: 32'h0});
    end else begin
      w   = ref_mem[a[11:2]];
      off = a % 4;
      n   = (f3 == 3'd0) ? 1 : 2;
      for (int unsigned i = 0; i < n; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
      merge_pending = 1'b1;
      merge_due     = cyc + 1;
      merge_a       = a & ~32'h3;
      merge_d       = w;
      rsp_q.push_back('{due: cyc + 2, err: 1'b0, rdata: 32'h0});
    end
  endtask

  // One clock cycle: drive a request, check every output at the falling edge, advance model.
  task automatic step(input logic v, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    logic ready_exp, legal, acc, in_merge, we_exp;
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    in_merge   = merge_pending && (merge_due == cyc);
    ready_exp  = !in_merge;
    legal      = !ref_err(we, f3, a);
    acc        = v && ready_exp;
    @(negedge clk);
    check("req_ready", {31'h0, req_ready}, {31'h0, ready_exp});
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      check("resp_valid", {31'h0, resp_valid}, 32'h1);
      check("resp_err", {31'h0, resp_err}, {31'h0, rsp_q[0].err});
      check("resp_rdata", resp_rdata, rsp_q[0].rdata);
      void'(rsp_q.pop_front());
    end else begin
      check("resp_idle", {31'h0, resp_valid}, 32'h0);
    end
    we_exp = in_merge || (acc && legal && we && f3 == 3'd2);
    check("mem_we", {31'h0, mem_we}, {31'h0, we_exp});
    if (in_merge) begin
      check("merge_addr", mem_addr, merge_a);
      check("merge_wdata", mem_wdata, merge_d);
    end else if (acc && legal) begin
      check("mem_addr", mem_addr, a & ~32'h3);
      if (we && f3 == 3'd2) check("sw_wdata", mem_wdata, wd);
    end
    @(posedge clk);
    if (in_merge) begin
      ref_mem[merge_a[11:2]] = merge_d;
      merge_pending = 1'b0;
    end
    if (acc) model_accept(we, f3, a, wd);
    cyc++;
    #1;
  endtask

  initial begin
    logic [31:0] w, a, wd;
    logic [2:0]  f3;
    int unsigned r;

    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      dmem[i]    = w;
      ref_mem[i] = w;
    end
    cyc = 0;
    merge_pending = 1'b0;
    merge_due = 0;
    merge_a = '0;
    merge_d = '0;

    // Reset held with a legal SW pending: nothing may be written or answered.
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0;
    req_wdata  = 32'hA5A5_0F0F;
    #1;
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    check("rst_mem_we2", {31'h0, mem_we}, 32'h0);
    check("rst_resp_valid2", {31'h0, resp_valid}, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 3'd2, 32'h0, 32'hA5A5_0F0F);

    // SW then back-to-back loads.
    step(1'b1, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 3'd0, 32'h103, 32'h0);
    step(1'b1, 1'b0, 3'd4, 32'h101, 32'h0);
    step(1'b1, 1'b0, 3'd1, 32'h102, 32'h0);
    step(1'b1, 1'b0, 3'd5, 32'h100, 32'h0);

    // SB read-modify-write, then a load of the merged word (held valid through MERGE).
    step(1'b1, 1'b1, 3'd0, 32'h101, 32'h1234_5655);
    step(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);

    // Error cases.
    step(1'b1, 1'b0, 3'd2, 32'h102, 32'h0);
    step(1'b1, 1'b1, 3'd1, 32'h101, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 3'd3, 32'h100, 32'h0);
    step(1'b1, 1'b1, 3'd4, 32'h100, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'hFFC, 32'h0);
    step(1'b1, 1'b1, 3'd1, 32'hFFE, 32'h0BAD_CAFE);
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'hFFC, 32'h0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    // Reset during MERGE discards the pending halfword write and its response.
    step(1'b1, 1'b1, 3'd1, 32'h202, 32'h0000_7777);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrg_rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("mrg_rst_ready", {31'h0, req_ready}, 32'h1);
    check("mrg_rst_resp", {31'h0, resp_valid}, 32'h0);
    #1;
    rst_n = 1'b1;
    merge_pending = 1'b0;
    rsp_q.delete();
    @(posedge clk);
    cyc++;
    #1;
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'h200, 32'h0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 9);
      f3 = (r > 7) ? 3'd2 : 3'(r);
      if (r == 3 || r == 6 || r == 7) f3 = ($urandom_range(0, 3) == 0) ? 3'(r) : 3'd2;
      r = $urandom_range(0, 19);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1000 + $urandom_range(0, 15);
      else             a = $urandom_range(0, 4095);
      if (r >= 2 && r < 9) a = a & ~32'h3;
      a  = (r >= 2 && $urandom_range(0, 1) == 0) ? (a & 32'h0000_003F) : a;
      wd = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, f3, a, wd);
    end
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    check("rsp_queue_drained", rsp_q.size(), 32'h0);
    for (int i = 0; i < 1024; i++) begin
      if (dmem[i] !== ref_mem[i]) check($sformatf("mem_word_%0d", i), dmem[i], ref_mem[i]);
    end
    check("mem_image_fp", dmem[64], ref_mem[64]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
